// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter that latches per-source edge pulses as pending events and presents them one at a time.
// Optional EDGE_EVENT_ARBITER_OVF_EN adds sticky per-source overflow flags (ovf_o) with a clear input (ovf_clr_i).
module edge_event_arbiter #(
    parameter int NUM_SRC = 32,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] edge_i,
    input  logic [NUM_SRC-1:0] mask_i,
    input  logic               evt_ready_i,
    output logic               evt_valid_o,
    output logic [ID_W-1:0]    evt_id_o,
    output logic [NUM_SRC-1:0] pending_o,
`ifdef EDGE_EVENT_ARBITER_OVF_EN
    output logic [NUM_SRC-1:0] ovf_o,
    input  logic               ovf_clr_i,
`endif
    output logic               busy_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr_vec;
    logic [ID_W-1:0]    scan_idx;
    logic [ID_W-1:0]    grant_id;
    logic               grant_found;
    logic               hs;

    assign eligible = pending_q & mask_i;
    assign hs       = (state_q == PRESENT) && evt_ready_i;

    // Scan upward from ptr; the ID_W-bit add wraps 31 -> 0 for free.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = ptr_q + ID_W'(k);
            if (!grant_found && eligible[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        clr_vec = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    id_d    = grant_id;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (hs) begin
                    clr_vec[id_q] = 1'b1;
                    ptr_d         = id_q + 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh edge in the acknowledge cycle re-arms the bit.
        pending_d = (pending_q & ~clr_vec) | edge_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
        end
    end

`ifdef EDGE_EVENT_ARBITER_OVF_EN
    logic [NUM_SRC-1:0] ovf_q, ovf_d;

    // An edge on a bit that stays pending is a lost event; set beats clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = '0;
        end
        ovf_d = ovf_d | (edge_i & pending_q & ~clr_vec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign evt_valid_o = (state_q == PRESENT);
    assign busy_o      = (state_q == PRESENT);
    assign evt_id_o    = id_q;
    assign pending_o   = pending_q;

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 32: number of edge sources; this revision supports exactly 32.
REQ-002 Parameter ID_W, default 5: width of event index, equal to log2(NUM_SRC).
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 edge_i  input  32: per-source edge pulses, one bit per source, from the edge_capture datapath.
REQ-006 mask_i  input  32: per-source enable; 1 makes the source eligible for grant.
REQ-007 evt_ready_i  input  1: consumer accepts the presented event.
REQ-008 evt_valid_o  output  1: an event is presented.
REQ-009 evt_id_o  output  5: index of the presented source.
REQ-010 pending_o  output  32: registered pending-event vector.
REQ-011 busy_o  output  1: high when FSM is in PRESENT.

Function
REQ-012 pending[i] SHALL set on the clock edge after edge_i[i]=1, regardless of mask_i[i].
REQ-013 Masked pending bits SHALL be held, not granted, and become eligible once unmasked.
REQ-014 FSM states SHALL be IDLE and PRESENT only.
REQ-015 IDLE: if (pending & mask_i) != 0, register round-robin winner into evt_id_o and go to PRESENT; else stay.
REQ-016 Round-robin SHALL search from pointer ptr upward, wrapping 31->0; first eligible bit wins.
REQ-017 PRESENT: evt_valid_o=1, busy_o=1; evt_id_o SHALL remain stable until handshake.
REQ-018 Handshake = evt_valid_o & evt_ready_i; on it clear pending[evt_id_o], set ptr=(evt_id_o+1) mod 32, return to IDLE.
REQ-019 Masking the presented source during PRESENT SHALL NOT withdraw the event.
REQ-020 If edge_i[k]=1 in the handshake cycle for k=evt_id_o, pending[k] SHALL remain 1 (new event wins over clear).
REQ-021 Latency: edge_i pulse at cycle N with FSM IDLE -> evt_valid_o=1 at cycle N+2.
REQ-022 Throughput: at most one event per two cycles (one IDLE bubble after each handshake).
REQ-023 evt_ready_i while evt_valid_o=0 SHALL have no effect.
REQ-024 Repeated edge_i on an already pending bit SHALL NOT produce an additional event.

Reset
REQ-025 reset=1 at a clock edge SHALL clear pending to 0, ptr to 0, FSM to IDLE, evt_valid_o=0, evt_id_o=0, busy_o=0.
REQ-026 Reset asserted during PRESENT SHALL drop the event without handshake; edge_i in reset cycles SHALL be ignored.

Configuration
REQ-027 Macro EDGE_EVENT_ARBITER_OVF_EN SHALL add outputs ovf_o[31:0] and input ovf_clr_i (1 bit).
REQ-028 With it defined: ovf_o[i] sets when edge_i[i]=1 while pending[i]=1 and not cleared that cycle; sticky; cleared to 0 by ovf_clr_i or reset; set wins over clear in same cycle.
REQ-029 Without it: ports and logic absent; behaviour otherwise identical.

Verification
REQ-030 Reset, edge_i=32'hA6, mask_i=all ones, evt_ready_i=1 -> events in order 1,2,5,7, each evt_valid_o one cycle, pending_o ends 0.
REQ-031 After id 7 granted (ptr=8), edge_i=32'h0000_0101 -> id 8 then id 0 (wrap).
REQ-032 edge_i=32'hBC, mask_i=32'h0F, evt_ready_i=1 -> ids 2,3 granted; pending_o=32'hB0 held; mask_i=all ones -> ids 4,5,7.
REQ-033 Present id 3, evt_ready_i=0 for 5 cycles while mask_i[3]=0 -> evt_valid_o=1, evt_id_o=3 held; ready=1 -> accepted.
REQ-034 edge_i[2]=1 in handshake cycle of id 2 -> pending_o[2]=1 after, id 2 re-presented; with EDGE_EVENT_ARBITER_OVF_EN, second pulse on pending bit 6 -> ovf_o=32'h40.
REQ-035 reset during PRESENT with pending_o=32'hEB -> next cycle evt_valid_o=0, pending_o=0, then edge_i=32'h1 -> id 0 at N+2.
